// File: rtl/addr_gen_burst.sv
// LC-3 address-generation unit: forms (PC|SR1) + sext(IR offset) and streams
// a burst of consecutive ascending or descending addresses over valid/ready.
module addr_gen_burst #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              addr1_sel,
  input  logic [1:0]        addr2_sel,
  input  logic [10:0]       ir_10_0,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] sr1_out,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              dir,
  output logic [DATA_W-1:0] addr_out,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              addr_last,
  output logic              busy
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                dir_q, dir_d;
  logic [DATA_W-1:0]   base_s;
  logic [DATA_W-1:0]   offset_s;

  // Offset selection; every code yields a defined value so addr_out never goes X
  function automatic logic [DATA_W-1:0] offset_f(input logic [1:0] sel,
                                                 input logic [10:0] ir);
    case (sel)
      2'b00:   offset_f = '0;
      2'b01:   offset_f = {{(DATA_W-6){ir[5]}}, ir[5:0]};
      2'b10:   offset_f = {{(DATA_W-9){ir[8]}}, ir[8:0]};
      2'b11:   offset_f = {{(DATA_W-11){ir[10]}}, ir[10:0]};
      default: offset_f = '0;
    endcase
  endfunction

  assign base_s   = addr1_sel ? sr1_out : pc;
  assign offset_s = offset_f(addr2_sel, ir_10_0);

  // State, address and remaining-beat registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state logic: capture request in IDLE, step one beat per accepted handshake
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = base_s + offset_s;
          rem_d   = burst_len;
          dir_d   = dir;
          state_d = EMIT;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (addr_ready) begin
          if (rem_q == '0) begin
            state_d = IDLE;
          end else begin
            addr_d = dir_q ? (addr_q - DATA_W'(1)) : (addr_q + DATA_W'(1));
            rem_d  = rem_q - CNT_W'(1);
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only; addr_ready has no path to them
  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q == EMIT);
  assign addr_valid = (state_q == EMIT);
  assign addr_last  = (state_q == EMIT) && (rem_q == '0);
  assign addr_out   = addr_q;

endmodule

// File: tb/tb_addr_gen_burst.sv
// Self-checking bench for addr_gen_burst: table of requests with a beat
// scoreboard, plus hand-written backpressure and mid-burst reset sequences.
module tb_addr_gen_burst;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        addr1_sel;
  logic [1:0]  addr2_sel;
  logic [10:0] ir_10_0;
  logic [15:0] pc;
  logic [15:0] sr1_out;
  logic [3:0]  burst_len;
  logic        dir;
  logic [15:0] addr_out;
  logic        addr_valid;
  logic        addr_ready;
  logic        addr_last;
  logic        busy;

  addr_gen_burst #(.DATA_W(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .addr1_sel(addr1_sel), .addr2_sel(addr2_sel), .ir_10_0(ir_10_0),
    .pc(pc), .sr1_out(sr1_out), .burst_len(burst_len), .dir(dir),
    .addr_out(addr_out), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .addr_last(addr_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        a1;
    logic [1:0]  a2;
    logic [10:0] ir;
    logic [15:0] pcv;
    logic [15:0] sr1;
    logic [3:0]  len;
    logic        d;
    logic [15:0] first;
  } vec_t;

  vec_t        vecs[9];
  logic [16:0] exp_q[$];   // {last, addr}
  int          checks_run = 0;
  int          checks_ok  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_run++;
    if (act === exp) checks_ok++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One cycle: sample at the falling edge, then step past the rising edge.
  task automatic tick();
    logic [16:0] e;
    @(negedge clk);
    if (addr_valid === 1'b1 && addr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {16'h0, addr_out}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("beat_addr", {16'h0, addr_out}, {16'h0, e[15:0]});
        check("beat_last", {31'h0, addr_last}, {31'h0, e[16]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input logic [15:0] first, input int n, input int total, input logic d);
    logic [15:0] a;
    a = first;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == total - 1), a});
      a = d ? a - 16'd1 : a + 16'd1;
    end
  endtask

  task automatic drive_req(input vec_t v);
    addr1_sel = v.a1;  addr2_sel = v.a2;  ir_10_0 = v.ir;
    pc = v.pcv;        sr1_out = v.sr1;   burst_len = v.len;  dir = v.d;
    req_valid = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    addr_ready = 1'b1;
    check($sformatf("v%0d_req_ready", idx), {31'h0, req_ready}, 32'h1);
    drive_req(v);
    push_beats(v.first, int'(v.len) + 1, int'(v.len) + 1, v.d);
    tick();
    req_valid = 1'b0;
    check($sformatf("v%0d_first_valid", idx), {31'h0, addr_valid}, 32'h1);
    check($sformatf("v%0d_busy", idx), {31'h0, busy}, 32'h1);
    drain($sformatf("v%0d", idx));
    check($sformatf("v%0d_idle_busy", idx), {31'h0, busy}, 32'h0);
    check($sformatf("v%0d_idle_valid", idx), {31'h0, addr_valid}, 32'h0);
    check($sformatf("v%0d_idle_req_ready", idx), {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t bp;
    //          a1    a2     ir       pc        sr1       len   dir   first
    vecs[0] = '{1'b0, 2'b10, 11'h1FF, 16'h3000, 16'h5555, 4'd0, 1'b0, 16'h2FFF};
    vecs[1] = '{1'b1, 2'b01, 11'h5A0, 16'hAAAA, 16'h4000, 4'd0, 1'b0, 16'h3FE0};
    vecs[2] = '{1'b1, 2'b00, 11'h5A0, 16'hAAAA, 16'h4000, 4'd0, 1'b0, 16'h4000};
    vecs[3] = '{1'b0, 2'b00, 11'h123, 16'hFFFE, 16'h1111, 4'd3, 1'b0, 16'hFFFE};
    vecs[4] = '{1'b0, 2'b11, 11'h400, 16'h3000, 16'h2222, 4'd2, 1'b1, 16'h2C00};
    vecs[5] = '{1'b1, 2'b01, 11'h01F, 16'h0000, 16'h1234, 4'd0, 1'b0, 16'h1253};
    vecs[6] = '{1'b0, 2'b10, 11'h0FF, 16'h0005, 16'h7777, 4'd15, 1'b1, 16'h0104};
    vecs[7] = '{1'b1, 2'b11, 11'h3FF, 16'h9999, 16'h0000, 4'd1, 1'b1, 16'h03FF};
    vecs[8] = '{1'b0, 2'b00, 11'h000, 16'h0001, 16'h0000, 4'd2, 1'b1, 16'h0001};

    rst = 1'b1; req_valid = 1'b0; addr_ready = 1'b0;
    addr1_sel = 1'b0; addr2_sel = 2'b00; ir_10_0 = 11'h0;
    pc = 16'h0; sr1_out = 16'h0; burst_len = 4'd0; dir = 1'b0;
    @(posedge clk); #1;
    tick(); tick();
    rst = 1'b0;
    check("rst_addr_out", {16'h0, addr_out}, 32'h0);
    check("rst_addr_valid", {31'h0, addr_valid}, 32'h0);
    check("rst_addr_last", {31'h0, addr_last}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], i);
      tick();
    end

    // Backpressure on the second beat of the wrapping burst
    bp = vecs[3];
    addr_ready = 1'b1;
    drive_req(bp);
    push_beats(16'hFFFE, 4, 4, 1'b0);
    tick();
    req_valid = 1'b0;
    tick();
    addr_ready = 1'b0;
    drive_req(vecs[0]);
    for (int i = 0; i < 3; i++) begin
      check("bp_addr_hold", {16'h0, addr_out}, 32'hFFFF);
      check("bp_last_low", {31'h0, addr_last}, 32'h0);
      check("bp_valid_high", {31'h0, addr_valid}, 32'h1);
      check("bp_req_ready_low", {31'h0, req_ready}, 32'h0);
      tick();
    end
    req_valid = 1'b0;
    addr_ready = 1'b1;
    drain("bp");
    check("bp_busy_after", {31'h0, busy}, 32'h0);
    tick();
    check("bp_no_stray_beat", {31'h0, addr_valid}, 32'h0);

    // Reset while the second beat of a 4-beat burst is on the bus
    bp = vecs[3];
    bp.pcv = 16'h1000;
    addr_ready = 1'b1;
    drive_req(bp);
    push_beats(16'h1000, 2, 4, 1'b0);
    tick();
    req_valid = 1'b0;
    tick();
    check("mid_addr_beat2", {16'h0, addr_out}, 32'h1001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_valid", {31'h0, addr_valid}, 32'h0);
    check("mid_rst_addr", {16'h0, addr_out}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_last", {31'h0, addr_last}, 32'h0);
    check("mid_rst_req_ready", {31'h0, req_ready}, 32'h1);
    run_vec(vecs[0], 100);

    tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks_ok, checks_run);
    $finish;
  end

endmodule

// File: doc/addr_gen_burst.md
Name: addr_gen_burst

Overview:
Parametrised address-generation unit for the LC-3 control path. It succeeds the combinational Addr1/Addr2 adder.
- Forms base = (PC or SR1) + sext(offset field of IR) and registers it.
- Can stream a burst of consecutive addresses (ascending or descending) to MAR/PC consumers over a valid/ready handshake.
- Used for single effective-address calculation and for sequential memory walks such as array sweeps in sort loops.

Parameters:
DATA_W, 16, address/data width; must be >= 12
CNT_W, 4, width of burst-length field; max burst = 2^CNT_W beats

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
addr1_sel  in  1  0: PC, 1: SR1
addr2_sel  in  2  00: zero, 01: sext(IR[5:0]), 10: sext(IR[8:0]), 11: sext(IR[10:0])
ir_10_0  in  11  instruction offset bits
pc  in  DATA_W  program counter
sr1_out  in  DATA_W  source register 1 value
burst_len  in  CNT_W  extra beats after the first; 0 = single address
dir  in  1  0: increment by 1 per beat, 1: decrement by 1
addr_out  out  DATA_W  generated address
addr_valid  out  1  addr_out valid
addr_ready  in  1  consumer accepts addr_out
addr_last  out  1  current beat is final beat of request
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, rst=1 at clock edge) forces the following, overriding everything including a mid-burst transfer:
  - state IDLE, addr_out=0, addr_valid=0, addr_last=0, busy=0
  - remaining count=0, latched dir=0
  - req_ready=1 in the first cycle after reset deasserts
- States: IDLE, EMIT.
- IDLE:
  - req_ready=1, addr_valid=0.
  - On req_valid=1 at an edge, all inputs are sampled that cycle:
    - addr_q <= addr1_mux + addr2_mux, modulo 2^DATA_W.
    - rem_q <= burst_len; dir_q <= dir; go to EMIT.
  - Inputs are ignored when req_valid=0 and in every non-IDLE state.
- Sign extension: IR[5:0], IR[8:0] and IR[10:0] are sign-extended to DATA_W using bit 5, 8 and 10 respectively. addr2_sel=00 yields 0. All four codes are defined; no X output.
- EMIT:
  - addr_valid=1, addr_out=addr_q, addr_last=(rem_q==0), req_ready=0, busy=1.
  - addr_valid && !addr_ready: addr_out, addr_last and internal state hold unchanged; no beat is skipped or repeated.
  - addr_valid && addr_ready && addr_last: go to IDLE; addr_valid=0 next cycle. A new request is accepted no earlier than the cycle after return to IDLE.
  - addr_valid && addr_ready && !addr_last: addr_q <= addr_q + 1 (dir_q=0) or addr_q - 1 (dir_q=1), wrapping modulo 2^DATA_W; rem_q <= rem_q - 1.
- Latency and throughput:
  - Request accepted at edge N gives first addr_valid in cycle N+1.
  - Burst beats stream one per cycle while addr_ready=1.
  - Single requests: at most one every 2 cycles.
- Beat count: total beats = burst_len + 1, range 1..2^CNT_W. The addr_q wrap FFFF->0000 (DATA_W=16) is legal and not flagged.
- Outputs are registered (from state/addr_q/rem_q), with no combinational path from addr_ready to addr_valid/addr_out. req_ready is a decode of state only.

Test Plan:
1. PC+off9 single:
   - Stimulus: pc=0x3000, addr1_sel=0, addr2_sel=10, ir_10_0[8:0]=0x1FF, burst_len=0.
   - Required: addr_out=0x2FFF, addr_valid=1, addr_last=1 one cycle after accept; IDLE after addr_ready.
2. SR1+off6:
   - Stimulus: sr1_out=0x4000, addr1_sel=1, addr2_sel=01, ir[5:0]=0x20.
   - Required: addr_out=0x3FE0. Repeat with addr2_sel=00 -> 0x4000.
3. Ascending burst with wrap:
   - Stimulus: pc=0xFFFE, addr2_sel=00, burst_len=3, dir=0, addr_ready=1.
   - Required: consecutive beats 0xFFFE, 0xFFFF, 0x0000, 0x0001; addr_last only on the 4th; busy drops the next cycle.
4. Descending burst with off11:
   - Stimulus: pc=0x3000, addr2_sel=11, ir=0x400, burst_len=2, dir=1.
   - Required: beats 0x2C00, 0x2BFF, 0x2BFE.
5. Backpressure:
   - Stimulus: during test 3, hold addr_ready=0 for 3 cycles on the 2nd beat.
   - Required: addr_out stays 0xFFFF with addr_last=0; sequence then continues with no loss or duplication. req_valid pulsed meanwhile is ignored (req_ready=0).
6. Reset mid-burst:
   - Stimulus: assert rst during beat 2 of a 4-beat burst.
   - Required: next cycle addr_valid=0, addr_out=0, busy=0, req_ready=1. A following request behaves as in test 1.
